// File: rtl/flr_req_handler.sv
// FLR request sequencer: queues FLR requests, pulses a per-function reset, waits for ack, returns a completion.
// Optional macro FLR_ACK_TIMEOUT_EN adds a WAIT_ACK timeout that forces the completion and sets ack_timeout.
module flr_req_handler #(
   parameter int FIFO_DEPTH  = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int ACK_TIMEOUT = 256,
   parameter int PF_WIDTH    = 3,
   parameter int VF_WIDTH    = 11
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flr_req_tvalid,
   input  logic [PF_WIDTH-1:0] flr_req_pf,
   input  logic [VF_WIDTH-1:0] flr_req_vf,
   input  logic                flr_req_vf_active,
   output logic                flr_rsp_tvalid,
   output logic [PF_WIDTH-1:0] flr_rsp_pf,
   output logic [VF_WIDTH-1:0] flr_rsp_vf,
   output logic                flr_rsp_vf_active,
   output logic                func_rst_valid,
   output logic [PF_WIDTH-1:0] func_rst_pf,
   output logic [VF_WIDTH-1:0] func_rst_vf,
   output logic                func_rst_vf_active,
   input  logic                func_rst_ack,
   output logic                busy,
   output logic                overflow,
   output logic [7:0]          drop_cnt,
   output logic                ack_timeout
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int EW = PF_WIDTH + VF_WIDTH + 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK, RESP} state_t;

   state_t          state_q, state_d;
   logic [EW-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [EW-1:0]   cur_q, cur_d;
   logic            overflow_q, overflow_d;
   logic [7:0]      drop_cnt_q, drop_cnt_d;
   logic            rst_valid_q, rst_valid_d;
   logic [EW-1:0]   rst_fn_q, rst_fn_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [EW-1:0]   rsp_fn_q, rsp_fn_d;
   logic            busy_q, busy_d;
   logic            push, pop, full;
   logic [EW-1:0]   req_entry;

`ifdef FLR_ACK_TIMEOUT_EN
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            ato_q, ato_d;
`endif

   assign req_entry = {flr_req_pf, flr_req_vf, flr_req_vf_active};
   assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
   assign pop       = (state_q == IDLE) && (count_q != '0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push      = flr_req_tvalid && (!full || pop);

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      hold_d     = hold_q;
      cur_d      = cur_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
`ifdef FLR_ACK_TIMEOUT_EN
      tmo_d      = tmo_q;
      ato_d      = ato_q;
`endif
      case (state_q)
         IDLE: begin
            if (pop) begin
               cur_d   = mem_q[rd_ptr_q];
               hold_d  = HW'(HOLD_CYCLES - 1);
               state_d = ASSERT;
            end
         end
         ASSERT: begin
            if (hold_q == '0) begin
               state_d = WAIT_ACK;
`ifdef FLR_ACK_TIMEOUT_EN
               tmo_d   = '0;
`endif
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         WAIT_ACK: begin
            if (func_rst_ack) begin
               state_d = RESP;
`ifdef FLR_ACK_TIMEOUT_EN
            end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
               state_d = RESP;
               ato_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      if (flr_req_tvalid && full && !pop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 1'b1;
      end

      // Outputs are precomputed from the next state so every port comes straight from a flop.
      rst_valid_d = (state_d == ASSERT);
      rst_fn_d    = rst_valid_d ? cur_d : '0;
      rsp_valid_d = (state_d == RESP);
      rsp_fn_d    = rsp_valid_d ? cur_d : '0;
      busy_d      = (state_d != IDLE) || (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= req_entry;
      cur_q  <= cur_d;
      hold_q <= hold_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
         rst_valid_q <= 1'b0;
         rst_fn_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_fn_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
         rst_valid_q <= rst_valid_d;
         rst_fn_q    <= rst_fn_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_fn_q    <= rsp_fn_d;
         busy_q      <= busy_d;
      end
   end

`ifdef FLR_ACK_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_q <= '0;
         ato_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         ato_q <= ato_d;
      end
   end
   assign ack_timeout = ato_q;
`else
   assign ack_timeout = 1'b0;
`endif

   assign func_rst_valid = rst_valid_q;
   assign {func_rst_pf, func_rst_vf, func_rst_vf_active} = rst_fn_q;
   assign flr_rsp_tvalid = rsp_valid_q;
   assign {flr_rsp_pf, flr_rsp_vf, flr_rsp_vf_active} = rsp_fn_q;
   assign busy     = busy_q;
   assign overflow = overflow_q;
   assign drop_cnt = drop_cnt_q;
endmodule
